// File: rtl/p1v_reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its surroundings.
// master: clock generator / pin side (drives requests, observes reset outputs).
// slave:  the sequencer itself.
interface p1v_reset_sequencer_if;
  logic       mmcm_locked;
  logic       rts_req;
  logic       btn_req;
  logic       wdog_kick;
  logic       inp_resn;
  logic [1:0] cause;
  logic [7:0] reset_count;

  modport master (
    output mmcm_locked, rts_req, btn_req, wdog_kick,
    input  inp_resn, cause, reset_count
  );

  modport slave (
    input  mmcm_locked, rts_req, btn_req, wdog_kick,
    output inp_resn, cause, reset_count
  );
endinterface

// File: rtl/p1v_reset_sequencer.sv
// P1V core reset sequencer: waits for a stable MMCM lock, stretches reset to a minimum
// width, then releases inp_resn. Re-enters reset on lock loss, host RTS, a debounced
// button press or (optionally) watchdog expiry, and records the cause of the last exit.
// Optional feature macro: P1V_RSTSEQ_WDOG_EN enables the watchdog.
module p1v_reset_sequencer #(
  parameter int unsigned LOCK_CYCLES     = 1024,
  parameter int unsigned HOLD_CYCLES     = 16000,
  parameter int unsigned DEBOUNCE_CYCLES = 160000,
  parameter int unsigned WDOG_CYCLES     = 1600000
) (
  input logic                  clock_160,
  input logic                  res,
  p1v_reset_sequencer_if.slave bus
);

  localparam int unsigned MaxLh = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxDw = (DEBOUNCE_CYCLES > WDOG_CYCLES) ? DEBOUNCE_CYCLES : WDOG_CYCLES;
  localparam int unsigned MaxCycles = (MaxLh > MaxDw) ? MaxLh : MaxDw;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StWaitLock, StHold, StWaitRel, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] deb_q, deb_d;
  logic            resn_q;
  logic [1:0]      cause_q, cause_d;
  logic [7:0]      count_q, count_d;
  logic            run_exit;
  logic            deb_hit;
  logic            wd_hit;

  assign deb_hit = (state_q == StRun) && bus.btn_req && (deb_q == DebLast);

`ifdef P1V_RSTSEQ_WDOG_EN
  localparam logic [CntW-1:0] WdogLast = CntW'(WDOG_CYCLES - 1);

  logic            kick_q;
  logic            kick_edge;
  logic [CntW-1:0] wd_q, wd_d;

  assign kick_edge = bus.wdog_kick ^ kick_q;
  // A kick in the same cycle as expiry wins: the core was still alive.
  assign wd_hit = (state_q == StRun) && (wd_q == WdogLast) && !kick_edge;

  // Watchdog idle counter: runs only in RUN, cleared by any kick edge.
  always_comb begin
    wd_d = '0;
    if (state_q == StRun && !kick_edge) begin
      wd_d = (wd_q == WdogLast) ? wd_q : wd_q + CntW'(1);
    end
  end

  // Watchdog registers; kick_q tracks the pin even during res so no false edge follows.
  always_ff @(posedge clock_160) begin
    kick_q <= bus.wdog_kick;
    if (res) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = bus.wdog_kick;
  assign wd_hit = 1'b0;
`endif

  // Button debounce: consecutive high samples while in RUN; cleared otherwise.
  always_comb begin
    deb_d = '0;
    if (state_q == StRun && bus.btn_req) begin
      deb_d = (deb_q == DebLast) ? deb_q : deb_q + CntW'(1);
    end
  end

  // Next state, shared counter and cause/count bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    count_d  = count_q;
    run_exit = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        if (!bus.mmcm_locked) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (!bus.mmcm_locked) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (bus.rts_req) begin
          // Hold is measured from the falling edge of rts_req.
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StWaitRel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitRel: begin
        if (!bus.mmcm_locked) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (!bus.btn_req) begin
          state_d = StRun;
        end
      end
      StRun: begin
        run_exit = 1'b1;
        if (!bus.mmcm_locked) begin
          state_d = StWaitLock;
          cause_d = 2'd0;
        end else if (bus.rts_req) begin
          state_d = StHold;
          cause_d = 2'd1;
        end else if (deb_hit) begin
          state_d = StHold;
          cause_d = 2'd2;
        end else if (wd_hit) begin
          state_d = StHold;
          cause_d = 2'd3;
        end else begin
          run_exit = 1'b0;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
    if (run_exit) begin
      cnt_d = '0;
      if (count_q != 8'hff) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  // State and output registers; inp_resn follows the next state so it is registered.
  always_ff @(posedge clock_160) begin
    if (res) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      deb_q   <= '0;
      resn_q  <= 1'b0;
      cause_q <= 2'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      resn_q  <= (state_d == StRun);
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  assign bus.inp_resn    = resn_q;
  assign bus.cause       = cause_q;
  assign bus.reset_count = count_q;

endmodule

// File: tb/tb_p1v_reset_sequencer.sv
// Bench for p1v_reset_sequencer: directed scenarios plus randomized traffic. Every cycle the
// stimulus side advances a behavioural model and queues the expected outputs; a monitor
// pops and compares after each clock edge.
module tb_p1v_reset_sequencer;

  localparam int Lock = 4;
  localparam int Hold = 8;
  localparam int Deb  = 5;
  localparam int Wdog = 20;

  logic clock_160 = 1'b0;
  logic res       = 1'b1;

  always #5 clock_160 = ~clock_160;

  p1v_reset_sequencer_if rs_if ();

  p1v_reset_sequencer #(
    .LOCK_CYCLES    (Lock),
    .HOLD_CYCLES    (Hold),
    .DEBOUNCE_CYCLES(Deb),
    .WDOG_CYCLES    (Wdog)
  ) dut (
    .clock_160(clock_160),
    .res      (res),
    .bus      (rs_if)
  );

  typedef struct packed {
    logic       resn;
    logic [1:0] cause;
    logic [7:0] count;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: phase plus "how long has X been true" quantities.
  localparam int PhLock = 0;
  localparam int PhHold = 1;
  localparam int PhRel  = 2;
  localparam int PhRun  = 3;

  int   ph          = PhLock;
  int   lock_streak = 0;
  int   hold_quiet  = 0;
  int   btn_streak  = 0;
  int   idle        = 0;
  logic prev_kick   = 1'b0;
  obs_t m           = '0;

  task automatic leave_run(input int nph, input int why);
    ph          = nph;
    m.cause     = 2'(why);
    m.count     = (m.count == 8'd255) ? 8'd255 : m.count + 8'd1;
    lock_streak = 0;
    hold_quiet  = 0;
  endtask

  task automatic model_step(input logic r, input logic lk, input logic rt, input logic bt,
                            input logic kk);
    logic kick_seen;
    kick_seen = (kk != prev_kick);
    prev_kick = kk;
    if (r) begin
      ph = PhLock; lock_streak = 0; hold_quiet = 0; btn_streak = 0; idle = 0; m = '0;
    end else begin
      case (ph)
        PhLock: begin
          lock_streak = lk ? lock_streak + 1 : 0;
          if (lock_streak == Lock) begin ph = PhHold; hold_quiet = 0; end
        end
        PhHold: begin
          if (!lk) begin ph = PhLock; lock_streak = 0; end
          else if (rt) hold_quiet = 0;
          else begin
            hold_quiet++;
            if (hold_quiet == Hold) ph = PhRel;
          end
        end
        PhRel: begin
          if (!lk) begin ph = PhLock; lock_streak = 0; end
          else if (!bt) begin ph = PhRun; btn_streak = 0; idle = 0; end
        end
        default: begin
          btn_streak = bt ? btn_streak + 1 : 0;
          idle       = kick_seen ? 0 : idle + 1;
          if (!lk) leave_run(PhLock, 0);
          else if (rt) leave_run(PhHold, 1);
          else if (btn_streak == Deb) leave_run(PhHold, 2);
`ifdef P1V_RSTSEQ_WDOG_EN
          else if (idle == Wdog) leave_run(PhHold, 3);
`endif
        end
      endcase
    end
    m.resn = (ph == PhRun);
  endtask

  // Advance one clock: model the inputs currently applied, queue expectation, step.
  task automatic tick();
    model_step(res, rs_if.mmcm_locked, rs_if.rts_req, rs_if.btn_req, rs_if.wdog_kick);
    exp_q.push_back(m);
    @(posedge clock_160);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Tick until inp_resn is high; number of ticks taken must equal want.
  task automatic expect_rise(input int limit, input int want, input string name);
    int n;
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (rs_if.inp_resn) break;
    end
    check(name, n, want);
  endtask

  // Scoreboard monitor.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clock_160);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{resn: rs_if.inp_resn, cause: rs_if.cause, count: rs_if.reset_count};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL scoreboard: got resn=%0b cause=%0d count=%0d, expected resn=%0b cause=%0d count=%0d at %0t",
                   a.resn, a.cause, a.count, e.resn, e.cause, e.count, $time);
        end
      end
    end
  end

  initial begin
    int lock_low, rts_left, btn_left, n;
    rs_if.mmcm_locked = 1'b1;
    rs_if.rts_req     = 1'b0;
    rs_if.btn_req     = 1'b0;
    rs_if.wdog_kick   = 1'b0;

    // Power-up: release 4 + 8 + 1 cycles after res falls.
    res = 1'b1;
    ticks(3);
    res = 1'b0;
    expect_rise(40, 13, "powerup_release");
    check("powerup_cause", rs_if.cause, 0);
    check("powerup_count", rs_if.reset_count, 0);
    ticks(5);

    // Lock flicker at lock count 2: release lands on edge 16 after res falls.
    res = 1'b1;
    tick();
    res = 1'b0;
    ticks(2);
    rs_if.mmcm_locked = 1'b0;
    tick();
    rs_if.mmcm_locked = 1'b1;
    expect_rise(40, 13, "flicker_release");
    ticks(3);

    // RTS held 10 cycles.
    rs_if.rts_req = 1'b1;
    tick();
    check("rts_assert_resn", rs_if.inp_resn, 0);
    ticks(9);
    rs_if.rts_req = 1'b0;
    expect_rise(40, 9, "rts_release");
    check("rts_cause", rs_if.cause, 1);
    check("rts_count", rs_if.reset_count, 1);

    // Button glitch then a long press.
    rs_if.btn_req = 1'b1;
    ticks(4);
    rs_if.btn_req = 1'b0;
    ticks(10);
    check("btn_glitch_resn", rs_if.inp_resn, 1);
    rs_if.btn_req = 1'b1;
    ticks(4);
    check("btn_before_debounce", rs_if.inp_resn, 1);
    tick();
    check("btn_debounced", rs_if.inp_resn, 0);
    ticks(25);
    check("btn_held_resn", rs_if.inp_resn, 0);
    rs_if.btn_req = 1'b0;
    expect_rise(40, 1, "btn_release");
    check("btn_cause", rs_if.cause, 2);
    check("btn_count", rs_if.reset_count, 2);

    // Lock loss and RTS in the same cycle: lock loss wins.
    ticks(3);
    rs_if.mmcm_locked = 1'b0;
    rs_if.rts_req     = 1'b1;
    tick();
    rs_if.mmcm_locked = 1'b1;
    rs_if.rts_req     = 1'b0;
    check("simul_cause", rs_if.cause, 0);
    check("simul_count", rs_if.reset_count, 3);
    expect_rise(60, 13, "simul_relock");

    // res in the middle of HOLD.
    ticks(3);
    rs_if.rts_req = 1'b1;
    tick();
    rs_if.rts_req = 1'b0;
    ticks(3);
    res = 1'b1;
    tick();
    check("res_mid_hold_resn", rs_if.inp_resn, 0);
    check("res_mid_hold_cause", rs_if.cause, 0);
    check("res_mid_hold_count", rs_if.reset_count, 0);
    res = 1'b0;
    expect_rise(60, 13, "after_res_release");

    // Watchdog.
    for (int k = 0; k < 10; k++) begin
      rs_if.wdog_kick = ~rs_if.wdog_kick;
      ticks(10);
    end
    check("wdog_kicked_resn", rs_if.inp_resn, 1);
`ifdef P1V_RSTSEQ_WDOG_EN
    rs_if.wdog_kick = ~rs_if.wdog_kick;
    n = 0;
    while (rs_if.inp_resn && n < 40) begin
      tick();
      n++;
    end
    check("wdog_expiry_delay", n, 21);
    check("wdog_cause", rs_if.cause, 3);
    expect_rise(40, 9, "wdog_release");
`else
    ticks(60);
    check("no_wdog_resn", rs_if.inp_resn, 1);
    tests++;
    if (rs_if.cause == 2'd3) begin
      fails++;
      $display("FAIL no_wdog_cause: got 3, expected not 3");
    end
`endif

    // Randomized traffic.
    lock_low = 0;
    rts_left = 0;
    btn_left = 0;
    for (int c = 0; c < 4000; c++) begin
      res = ($urandom_range(0, 599) == 0);
      if (lock_low > 0) begin
        rs_if.mmcm_locked = 1'b0;
        lock_low--;
      end else begin
        rs_if.mmcm_locked = 1'b1;
        if ($urandom_range(0, 299) == 0) lock_low = $urandom_range(1, 6);
      end
      if (rts_left > 0) begin
        rs_if.rts_req = 1'b1;
        rts_left--;
      end else begin
        rs_if.rts_req = 1'b0;
        if ($urandom_range(0, 149) == 0) rts_left = $urandom_range(1, 15);
      end
      if (btn_left > 0) begin
        rs_if.btn_req = 1'b1;
        btn_left--;
      end else begin
        rs_if.btn_req = 1'b0;
        if ($urandom_range(0, 59) == 0) btn_left = $urandom_range(1, 10);
      end
      if ($urandom_range(0, 11) == 0) rs_if.wdog_kick = ~rs_if.wdog_kick;
      tick();
    end
    res = 1'b0;
    ticks(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
